// File: rtl/xm23_fetch_unit_if.sv
// Fetch-stage bundle: pipeline control in, instruction memory port, and fetch slot out.
interface xm23_fetch_unit_if;
  logic [7:0]  stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] fetch_out;
  logic [15:0] fetch_pc;
  logic        fetch_valid;

  modport master (
    input  stall_in, redirect, redirect_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, fetch_out, fetch_pc, fetch_valid
  );

  modport slave (
    output stall_in, redirect, redirect_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, fetch_out, fetch_pc, fetch_valid
  );
endinterface

// File: rtl/xm23_fetch_unit.sv
// XM23 fetch: one read in flight, slot valid 1 cycle after imem_rvalid, one word/cycle streaming.
// A stalled full slot parks the returning word in a one-entry skid; no reads until it drains.
module xm23_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input logic               clk,
  input logic               rst_n,
  xm23_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic [15:0] out_q, out_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic        out_vld_q, out_vld_d;
  logic [15:0] skid_dat_q, skid_dat_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic        drop_q, drop_d;
  logic        req_c;

  logic stalled;
  logic slot_free;

  assign stalled   = |bus.stall_in;
  assign slot_free = !out_vld_q || !stalled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      out_q      <= 16'h0000;
      out_pc_q   <= RESET_PC;
      out_vld_q  <= 1'b0;
      skid_dat_q <= 16'h0000;
      skid_pc_q  <= 16'h0000;
      skid_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      out_q      <= out_d;
      out_pc_q   <= out_pc_d;
      out_vld_q  <= out_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_pc_q  <= skid_pc_d;
      skid_vld_q <= skid_vld_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    out_d      = out_q;
    out_pc_d   = out_pc_q;
    out_vld_d  = out_vld_q;
    skid_dat_d = skid_dat_q;
    skid_pc_d  = skid_pc_q;
    skid_vld_d = skid_vld_q;
    drop_d     = drop_q;
    req_c      = 1'b0;

    // Consumed slot empties unless something below reloads it this edge.
    if (out_vld_q && !stalled) begin
      out_vld_d = 1'b0;
      out_d     = 16'h0000;
    end

    if (bus.redirect) begin
      pc_d       = bus.redirect_pc & 16'hFFFE;
      out_vld_d  = 1'b0;
      out_d      = 16'h0000;
      skid_vld_d = 1'b0;
      // A read still in flight must be swallowed when it finally returns.
      if (state_q == S_WAIT && !bus.imem_rvalid) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (slot_free) begin
            req_c    = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + 16'(PC_STEP);
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_IDLE;
            end else if (slot_free) begin
              out_d     = bus.imem_rdata;
              out_pc_d  = req_pc_q;
              out_vld_d = 1'b1;
              req_c     = 1'b1;
              req_pc_d  = pc_q;
              pc_d      = pc_q + 16'(PC_STEP);
            end else begin
              skid_dat_d = bus.imem_rdata;
              skid_pc_d  = req_pc_q;
              skid_vld_d = 1'b1;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stalled) begin
            out_d      = skid_dat_q;
            out_pc_d   = skid_pc_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.imem_req    = req_c & rst_n;
  assign bus.imem_addr   = pc_q;
  assign bus.fetch_out   = out_q;
  assign bus.fetch_pc    = out_pc_q;
  assign bus.fetch_valid = out_vld_q;

endmodule

// File: tb/tb_xm23_fetch_unit.sv
// Directed bench for xm23_fetch_unit: behavioural memory with variable latency and a scoreboard monitor.
module tb_xm23_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xm23_fetch_unit_if bus();

  xm23_fetch_unit #(.RESET_PC(16'h0100), .PC_STEP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = 16'h0000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc, input int c);
    exp_t e;
    e.pc  = pc;
    e.dat = pc ^ 16'hA5A5;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // One clock cycle: drive inputs at negedge, answer memory, capture any request.
  task automatic step(input logic [7:0] st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    bus.stall_in    = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    if (mem_cnt > 0) begin
      mem_cnt--;
      bus.imem_rvalid = (mem_cnt == 0);
      bus.imem_rdata  = (mem_cnt == 0) ? (mem_addr ^ 16'hA5A5) : 16'h0000;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 16'h0000;
    end
    #1;
    if (bus.imem_req) begin
      chk("single_outstanding", 16'(mem_cnt), 16'h0000);
      mem_addr = bus.imem_addr;
      mem_cnt  = lat;
    end
    #2;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max) begin
      step(8'h00, 1'b0, 16'h0000);
      n++;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    step(8'hFF, 1'b0, 16'h0000);
  endtask

  task automatic settle();
    repeat (5) step(8'hFF, 1'b0, 16'h0000);
  endtask

  // Monitor: every consumed slot must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.fetch_valid && bus.stall_in == 8'h00) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_fetch: got pc %h, expected none", bus.fetch_pc);
        end else begin
          e = sb.pop_front();
          chk("fetch_pc", bus.fetch_pc, e.pc);
          chk("fetch_out", bus.fetch_out, e.dat);
          if (e.cyc >= 0) chk("fetch_cycle", 16'(cyc), 16'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.stall_in    = 8'h00;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_fetch_valid", {15'h0, bus.fetch_valid}, 16'h0000);
    chk("rst_fetch_out", bus.fetch_out, 16'h0000);
    chk("rst_fetch_pc", bus.fetch_pc, 16'h0100);
    chk("rst_imem_req", {15'h0, bus.imem_req}, 16'h0000);

    // Streaming from reset with a 3-cycle stall (cycles 5..7)
    cyc = -1;
    push(16'h0100, 2);  push(16'h0102, 3);  push(16'h0104, 4);
    push(16'h0106, 8);  push(16'h0108, 9);  push(16'h010A, 11);
    push(16'h010C, 12);
    for (int i = 0; i < 13; i++) begin
      step((i >= 5 && i <= 7) ? 8'h01 : 8'h00, 1'b0, 16'h0000);
      if (i == 0) begin
        chk("first_req", {15'h0, bus.imem_req}, 16'h0001);
        chk("first_addr", bus.imem_addr, 16'h0100);
      end
      if (i >= 5 && i <= 7) chk("no_req_stalled", {15'h0, bus.imem_req}, 16'h0000);
    end
    drain(20);

    // Redirect with a 3-cycle read in flight
    lat = 3;
    settle();
    step(8'hFF, 1'b1, 16'h0500);
    step(8'h00, 1'b0, 16'h0000);
    chk("redir_stall_flush", {15'h0, bus.fetch_valid}, 16'h0000);
    chk("redir_req", {15'h0, bus.imem_req}, 16'h0001);
    chk("redir_addr", bus.imem_addr, 16'h0500);
    step(8'h00, 1'b1, 16'h0201);
    chk("no_req_on_redirect", {15'h0, bus.imem_req}, 16'h0000);
    push(16'h0200, -1);
    push(16'h0202, -1);
    for (int k = 3; k <= 8; k++) begin
      step(8'h00, 1'b0, 16'h0000);
      chk("drop_valid_low", {15'h0, bus.fetch_valid}, 16'h0000);
      if (k == 4) chk("drop_no_chain", {15'h0, bus.imem_req}, 16'h0000);
      if (k == 5) begin
        chk("post_drop_req", {15'h0, bus.imem_req}, 16'h0001);
        chk("post_drop_addr", bus.imem_addr, 16'h0200);
      end
    end
    drain(40);

    // Back-to-back redirects while a dropped read is outstanding
    settle();
    step(8'hFF, 1'b1, 16'h0600);
    step(8'h00, 1'b0, 16'h0000);
    chk("b2b_req", bus.imem_addr, 16'h0600);
    step(8'h00, 1'b1, 16'h0300);
    chk("b2b_no_req1", {15'h0, bus.imem_req}, 16'h0000);
    step(8'h00, 1'b1, 16'h0400);
    chk("b2b_no_req2", {15'h0, bus.imem_req}, 16'h0000);
    step(8'h00, 1'b0, 16'h0000);
    chk("b2b_drop_no_req", {15'h0, bus.imem_req}, 16'h0000);
    push(16'h0400, -1);
    push(16'h0402, -1);
    step(8'h00, 1'b0, 16'h0000);
    chk("b2b_addr", bus.imem_addr, 16'h0400);
    chk("b2b_req_live", {15'h0, bus.imem_req}, 16'h0001);
    drain(40);

    // Address wrap; bit 0 of the redirect target is ignored
    lat = 1;
    settle();
    step(8'hFF, 1'b1, 16'hFFFF);
    push(16'hFFFE, -1);
    push(16'h0000, -1);
    push(16'h0002, -1);
    drain(20);

    // Asynchronous reset while holding a full skid
    settle();
    rst_n = 1'b0;
    mem_cnt = 0;
    bus.imem_rvalid = 1'b0;
    #1;
    chk("arst_fetch_valid", {15'h0, bus.fetch_valid}, 16'h0000);
    chk("arst_fetch_out", bus.fetch_out, 16'h0000);
    chk("arst_fetch_pc", bus.fetch_pc, 16'h0100);
    chk("arst_imem_req", {15'h0, bus.imem_req}, 16'h0000);
    cyc = -1;
    push(16'h0100, 2);
    push(16'h0102, 3);
    push(16'h0104, 4);
    step(8'h00, 1'b0, 16'h0000);
    chk("restart_addr", bus.imem_addr, 16'h0100);
    chk("restart_req", {15'h0, bus.imem_req}, 16'h0001);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/xm23_fetch_unit.md
# xm23_fetch_unit

Instruction fetch stage of the XM23 pipeline. It sits directly upstream of the decode/pipeline-register stage. It owns the program counter and issues word reads to instruction memory with at most one read outstanding. It presents one instruction per cycle on `fetch_out`, which feeds `fetch_in` of the pipeline registers, and it obeys the same 8-bit `stall_in` vector. Branch redirects flush the fetch slot and any in-flight read.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `PC_STEP`, 2: byte increment between sequential XM23 words.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall_in`  in  8: the fetch slot is held when any bit is set. This is the same vector the pipeline registers receive.
- `redirect`  in  1: taken branch or exception; takes priority over everything except reset.
- `redirect_pc`  in  16: new fetch address; bit 0 is ignored (forced to 0).
- `imem_req`  out  1: read strobe, valid for one cycle per read.
- `imem_addr`  out  16: read address; always even.
- `imem_rvalid`  in  1: read data valid, 1 or more cycles after `imem_req`.
- `imem_rdata`  in  16: instruction word.
- `fetch_out`  out  16: instruction presented to decode.
- `fetch_pc`  out  16: address of `fetch_out`.
- `fetch_valid`  out  1: the fetch slot holds a live instruction.

## Operation
- **Registers:**
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding read.
  - Output slot: `fetch_out`, `fetch_pc`, `fetch_valid`.
  - One-entry skid buffer: `skid_data`, `skid_pc`, `skid_valid`.
  - `drop`: discard flag.
  - FSM state.
- **Slot free:** `!fetch_valid || !(|stall_in)`. The slot is consumed at any edge where `|stall_in == 0`.
- **FSM states IDLE / WAIT / HOLD:**
  - **IDLE:** no read outstanding.
    - If the slot is free and `redirect` = 0: drive `imem_req` = 1 and `imem_addr` = `pc`, load `req_pc <= pc` and `pc <= pc + PC_STEP`, then go to WAIT.
  - **WAIT:** read outstanding. On `imem_rvalid`:
    - If `drop` = 1: discard the data, clear `drop`, go to IDLE.
    - Else if the slot is free: load the slot with `{imem_rdata, req_pc, 1}`.
      - In the same cycle, chain the next read (`imem_req` = 1 at `pc`, update `req_pc`/`pc`, stay in WAIT).
      - This gives one instruction per cycle with zero-wait memory.
    - Else: load the skid buffer and go to HOLD. No read is issued.
  - **HOLD:** skid full, no reads issued.
    - When `|stall_in == 0`, the skid moves into the slot, `skid_valid` clears, and the FSM goes to IDLE.
- **Slot drain:** if the slot is consumed and nothing new is loaded, `fetch_valid` goes to 0 and `fetch_out` goes to 16'h0000.
- **Redirect** (level-sampled at the edge):
  - `pc <= redirect_pc & 16'hFFFE`.
  - Slot and skid are invalidated (`fetch_out` = 0).
  - If in WAIT without `imem_rvalid` in the same cycle, set `drop` and stay in WAIT. Otherwise go to IDLE.
  - No `imem_req` is issued in a redirect cycle.
  - Redirect while `drop` is already set: update `pc` only.
- **Address arithmetic:** 16-bit, wraps 16'hFFFE -> 16'h0000 with no flag.
- **Data response ordering:** `imem_rvalid` outside WAIT is ignored. Memory must not return data unrequested.

## Timing
- **Reset values (asynchronous, while `rst_n` = 0):**
  - State = IDLE.
  - `pc` = `RESET_PC`, `req_pc` = `RESET_PC`.
  - `fetch_out` = 0, `fetch_pc` = `RESET_PC`, `fetch_valid` = 0.
  - `skid_valid` = 0, `drop` = 0, `imem_req` = 0.
- **First read after reset:** `imem_req` is asserted in the first cycle after `rst_n` deasserts.
- **Latency:** `fetch_out` is valid 1 cycle after `imem_rvalid`.
  - With single-cycle memory, the first instruction is valid 2 cycles after reset release, then one per cycle.
- **`imem_req`:** combinational from state and inputs. `imem_addr` always equals `pc` when `imem_req` = 1.
- **Stall/rvalid interaction:** a stall asserted in the same cycle as `imem_rvalid` with a full slot routes the data to the skid buffer. It is never lost or duplicated.
- **Reset mid-read:** the reset clears all state. A late `imem_rvalid` is then ignored, because the FSM is in IDLE.
- **Redirect + stall:** a redirect in the same cycle as a stall still flushes the slot.

## Test plan
- **Reset and streaming:** reset with `RESET_PC` = 16'h0100, single-cycle memory returning `addr ^ 16'hA5A5`.
  - Required: `fetch_pc` sequence 0100, 0102, 0104 on consecutive cycles from cycle 2, with matching data.
- **Stall mid-stream:** hold `stall_in` = 8'h01 for 3 cycles during streaming.
  - Required: the slot holds its value, the skid captures exactly one word, no `imem_req` while in HOLD.
  - On release: consecutive PCs with no gap and no duplicate.
- **Redirect with data in flight:** memory latency 3; assert `redirect`/`redirect_pc` = 16'h0201 one cycle after `imem_req`.
  - Required: the returning word is dropped, the next `imem_addr` = 16'h0200, and `fetch_valid` stays 0 until the new data arrives.
- **Back-to-back redirects:** redirect to 0x0300, then 0x0400 on the next cycle, during `drop`.
  - Required: only 0x0400 is fetched.
- **Wrap-around:** redirect to 16'hFFFE.
  - Required: the next sequential `fetch_pc` is 16'h0000.
- **Async reset during HOLD:** assert `rst_n` low between clock edges while in HOLD.
  - Required: `fetch_valid` drops immediately, the skid clears, and fetch restarts at `RESET_PC`.
